// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit active-low seven-segment display.
// Double-buffers frames, blanks between digits and applies 16-level brightness PWM.
module seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] frame_i,
  input  logic        frame_valid_i,
  output logic        frame_ready_o,
  input  logic [3:0]  bright_i,
  output logic [3:0]  an_o,
  output logic [7:0]  seg_o,
  output logic [1:0]  digit_o,
  output logic        frame_done_o
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_pwm;
  logic [3:0]    r_bright;
  logic [31:0]   r_active;
  logic [31:0]   r_pending;
  logic          r_pend_full;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;
  logic [1:0]    r_digit;
  logic          r_done;
  logic          r_ready;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_pwm_nxt;
  logic [3:0]    w_bright_nxt;
  logic          w_wrap;
  logic          w_accept;
  logic          w_pend_full_nxt;
  logic [31:0]   w_active_nxt;
  logic [31:0]   w_pending_nxt;
  logic [3:0]    w_an_nxt;
  logic [7:0]    w_seg_nxt;

  // Next-state logic; outputs are derived from next state so the registered
  // pins line up with the state they describe.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_ONE;
    w_idx_nxt    = r_idx;
    w_pwm_nxt    = r_pwm;
    w_bright_nxt = r_bright;
    w_wrap       = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt  = ST_ON;
          w_cnt_nxt    = '0;
          w_pwm_nxt    = 4'd0;
          w_bright_nxt = bright_i;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_ON: begin
        w_pwm_nxt = r_pwm + 4'd1;
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
          w_wrap      = (r_idx == 2'd3);
        end else begin
          w_state_nxt = ST_ON;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase

    // A frame arriving on the wrap edge lands in pending, never directly in active.
    w_accept        = frame_valid_i & r_ready;
    w_pend_full_nxt = w_accept | (r_pend_full & ~w_wrap);
    w_pending_nxt   = w_accept ? frame_i : r_pending;
    w_active_nxt    = (w_wrap & r_pend_full) ? r_pending : r_active;

    w_an_nxt  = 4'hF;
    w_seg_nxt = 8'hFF;
    if (w_state_nxt == ST_ON) begin
      w_seg_nxt = w_active_nxt[{w_idx_nxt, 3'b000} +: 8];
      if (w_pwm_nxt <= w_bright_nxt) begin
        w_an_nxt = ~(4'b0001 << w_idx_nxt);
      end else begin
        w_an_nxt = 4'hF;
      end
    end else begin
      w_seg_nxt = 8'hFF;
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_BLANK;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_pwm       <= 4'd0;
      r_bright    <= 4'd0;
      r_active    <= 32'hFFFF_FFFF;
      r_pending   <= 32'hFFFF_FFFF;
      r_pend_full <= 1'b0;
      r_an        <= 4'hF;
      r_seg       <= 8'hFF;
      r_digit     <= 2'd0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_pwm       <= w_pwm_nxt;
      r_bright    <= w_bright_nxt;
      r_active    <= w_active_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_an        <= w_an_nxt;
      r_seg       <= w_seg_nxt;
      r_digit     <= w_idx_nxt;
      r_done      <= w_wrap;
      r_ready     <= ~w_pend_full_nxt;
    end
  end

  assign an_o          = r_an;
  assign seg_o         = r_seg;
  assign digit_o       = r_digit;
  assign frame_done_o  = r_done;
  assign frame_ready_o = r_ready;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit, 8-bit-per-digit, active-low seven-segment frame that the message formatter produces (digit k = frame[8k+7:8k], bit 0 = dp).
- Double-buffers incoming frames and swaps them only at a scan wrap, so a frame never tears mid-scan.
- Sequences the anodes with an inter-digit blanking gap to kill ghosting, and applies 16-level brightness PWM.
- Sits between the message formatter and the board's anode/segment pins.

Parameters:
- DWELL_CYCLES, 50000: clock cycles each digit spends in the ON phase (1 kHz per digit at 50 MHz); must be at least 1.
- BLANK_CYCLES, 500: clock cycles of all-anodes-off between digits; must be at least 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- frame_i  in  32  new display frame; active-low segments; digit k in bits [8k+7:8k]
- frame_valid_i  in  1  frame_i is offered
- frame_ready_o  out  1  pending buffer is empty, so a frame can be accepted
- bright_i  in  4  brightness level, 0 = 1/16 duty, 15 = full duty
- an_o  out  4  active-low anode enables; an_o[k] drives digit k
- seg_o  out  8  active-low segments {a,b,c,d,e,f,g,dp} for the lit digit
- digit_o  out  2  index of the digit currently being scanned
- frame_done_o  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- All outputs are registered.
- Reset values: an_o=4'hF, seg_o=8'hFF, digit_o=0, frame_done_o=0, frame_ready_o=1.
- Reset internal state: active buffer=32'hFFFFFFFF, pending buffer empty, state=BLANK, phase counter=0, pwm counter=0.
- Reset applied at any point, including mid-ON or on a swap cycle, returns everything to the reset values on the next edge and discards any pending frame.
- FSM, two states:
  - BLANK: an_o=4'hF, seg_o=8'hFF. Lasts BLANK_CYCLES cycles, then goes to ON with the phase counter cleared.
  - ON: seg_o=active[8*idx+7 : 8*idx]. an_o[idx]=0 when pwm_cnt <= bright_q, otherwise 4'hF. Lasts DWELL_CYCLES cycles.
  - On exit from ON: idx <= idx+1 mod 4, state goes to BLANK.
- PWM:
  - pwm_cnt is 4 bits, is cleared on entry to ON, increments every ON cycle and wraps 15→0.
  - bright_q samples bright_i on entry to ON; bright_i changes mid-digit take effect at the next digit.
- At most one an_o bit is low at any time. Between two lit digits there are always at least BLANK_CYCLES all-off cycles.
- Scan period is 4*(BLANK_CYCLES+DWELL_CYCLES) cycles. digit_o = idx throughout both BLANK and ON.
- Handshake:
  - A frame is accepted when frame_valid_i & frame_ready_o at an edge; frame_i is latched into pending and pending becomes full.
  - While pending is full, frame_ready_o=0 and frame_i is ignored.
- Scan wrap (last cycle of ON with idx=3):
  - frame_done_o=1 for exactly one cycle, the first BLANK cycle of idx 0.
  - If pending is full: active <= pending, pending becomes empty, and frame_ready_o returns to 1 on the same edge.
- Simultaneous accept and wrap with pending empty: the new frame goes into pending, not active, and is displayed from the following scan.
- Phase counter width is clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). Counter values never wrap in normal operation.
- frame_i persists only in the buffers; the controller never drives segments combinationally from frame_i.

Test Plan (DWELL_CYCLES=8, BLANK_CYCLES=2, bright_i=15 unless noted):
- Reset release → an_o=F, seg_o=FF for 2 cycles. Then 8 cycles with an_o=1110, seg_o=FF (empty frame). frame_ready_o=1 throughout. frame_done_o pulses once, 40 cycles after release.
- Offer 32'h11223344 one cycle after reset → accepted, frame_ready_o=0 until the first wrap. The second scan shows 44 on an_o=1110, 33 on 1101, 22 on 1011, 11 on 0111.
- Offer A, then B on the next cycle, holding valid → B stalled (ready=0) until the first wrap. B is accepted at the wrap+1 edge and displayed one scan after A.
- bright_i=3 → in each 8-cycle ON window the anode is low for ON cycles 0-3 and high for 4-7. bright_i=0 → low for 1 cycle only. bright_i=15 → low for all 8 cycles.
- Assert rst_i for 1 cycle during the ON phase of digit 2 with a pending frame present → next edge gives an_o=F, seg_o=FF, digit_o=0, ready=1. The following scan shows FF on all digits.
- Checker over a random run with random frames and brightness → never more than one an_o bit low. At least 2 all-off cycles between distinct lit digits. frame_done_o spacing is exactly 40 cycles.
